// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver: parity modes, receiver FSM
// states, the default oversampling ratio and the character-length clamp.
package uart_pkg;

  localparam int OVS_DEF = 16;

  typedef enum logic [2:0] {
    PAR_NONE  = 3'd0,
    PAR_EVEN  = 3'd1,
    PAR_ODD   = 3'd2,
    PAR_MARK  = 3'd3,
    PAR_SPACE = 3'd4
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_PARITY  = 3'd3,
    ST_STOP1   = 3'd4,
    ST_STOP2   = 3'd5,
    ST_BRKWAIT = 3'd6
  } rx_state_e;

  function automatic logic [3:0] clamp_bits(input logic [3:0] req, input int max_w);
    if (req < 4'd5) return 4'd5;
    if (int'(req) > max_w) return 4'(max_w);
    return req;
  endfunction

  // Unused encodings above SPACE receive as no-parity frames.
  function automatic parity_e to_parity(input logic [2:0] raw);
    return (raw > 3'd4) ? PAR_NONE : parity_e'(raw);
  endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Character output channel of the UART receiver plus an FSM state debug tap.
// Handshake: o_valid with o_data and its flags stays stable until the cycle in which o_valid && i_ready.
interface uart_rx_core_if #(parameter int DATA_W_MAX = 9);
  import uart_pkg::*;

  logic [DATA_W_MAX-1:0] o_data;
  logic                  o_valid;
  logic                  i_ready;
  logic                  o_parity_err;
  logic                  o_frame_err;
  logic                  o_break;
  rx_state_e             dbg_state;

  modport master (
    output o_data, o_valid, o_parity_err, o_frame_err, o_break, dbg_state,
    input  i_ready
  );

  modport slave (
    input  o_data, o_valid, o_parity_err, o_frame_err, o_break, dbg_state,
    output i_ready
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one pulse every max(i_div,1) clocks, parked at 0 while held.
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_hold,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] last;

  assign last   = (i_div == '0) ? '0 : i_div - 1'b1;
  assign o_tick = !i_hold && (cnt == last);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (i_hold || cnt == last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: synchronizes the line, samples each bit by 2-of-3 majority around
// mid-bit, checks parity/stop/break and presents characters on a valid/ready channel.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_W_MAX = 9,
  parameter int OVS        = OVS_DEF,
  parameter int DIV_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_rx,
  input  logic [DIV_W-1:0] i_div,
  input  logic [3:0]       i_data_bits,
  input  logic [2:0]       i_parity,
  input  logic             i_stop2,
  uart_rx_core_if.master   rx_if,
  output logic             o_overrun,
  input  logic             i_clr_ovr,
  output logic             o_busy
);
  localparam int SC_W = $clog2(OVS);
  localparam logic [SC_W-1:0] SMP_A   = SC_W'(OVS / 2 - 1);
  localparam logic [SC_W-1:0] SMP_B   = SC_W'(OVS / 2);
  localparam logic [SC_W-1:0] SMP_C   = SC_W'(OVS / 2 + 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVS - 1);

  logic rx_meta, rx_sync, rx_prev;
  logic tick, tick_hold;

  rx_state_e             state;
  logic [SC_W-1:0]       sc;
  logic                  smp_a, smp_b;
  logic [3:0]            bitcnt, nb_l;
  parity_e               par_l;
  logic                  stop2_l;
  logic [DATA_W_MAX-1:0] shreg;
  logic                  par_acc, all_zero, perr, ferr, hi_seen;

  logic                  fall, mid, maj, par_exp, brk_now, fin;
  logic [DATA_W_MAX-1:0] data_q;
  logic                  valid_q, perr_q, ferr_q, brk_q, ovr_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign tick_hold = (state == ST_IDLE);

  uart_baud_tick #(.DIV_W(DIV_W)) u_baud_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_hold (tick_hold),
    .i_div  (i_div),
    .o_tick (tick)
  );

  // The third sample is taken live, so the bit decision lands on the SMP_C tick.
  always_comb begin
    fall    = rx_prev && !rx_sync;
    mid     = tick && (sc == SMP_C);
    maj     = (smp_a & smp_b) | (smp_a & rx_sync) | (smp_b & rx_sync);
    par_exp = 1'b0;
    case (par_l)
      PAR_EVEN: par_exp = par_acc;
      PAR_ODD:  par_exp = !par_acc;
      PAR_MARK: par_exp = 1'b1;
      default:  par_exp = 1'b0;
    endcase
    brk_now = (state == ST_STOP1) && all_zero && !maj;
    fin     = mid && (brk_now || (state == ST_STOP1 && !stop2_l) || state == ST_STOP2);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      sc       <= '0;
      smp_a    <= 1'b1;
      smp_b    <= 1'b1;
      bitcnt   <= '0;
      nb_l     <= 4'd8;
      par_l    <= PAR_NONE;
      stop2_l  <= 1'b0;
      shreg    <= '0;
      par_acc  <= 1'b0;
      all_zero <= 1'b0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      hi_seen  <= 1'b0;
    end else begin
      if (tick) begin
        sc <= (sc == SC_LAST) ? '0 : sc + 1'b1;
        if (sc == SMP_A) smp_a <= rx_sync;
        if (sc == SMP_B) smp_b <= rx_sync;
      end
      case (state)
        ST_IDLE: if (fall) begin
          nb_l     <= clamp_bits(i_data_bits, DATA_W_MAX);
          par_l    <= to_parity(i_parity);
          stop2_l  <= i_stop2;
          sc       <= '0;
          bitcnt   <= '0;
          shreg    <= '0;
          par_acc  <= 1'b0;
          all_zero <= 1'b1;
          perr     <= 1'b0;
          ferr     <= 1'b0;
          state    <= ST_START;
        end
        ST_START: if (mid) state <= maj ? ST_IDLE : ST_DATA;
        ST_DATA: if (mid) begin
          shreg[bitcnt] <= maj;
          par_acc       <= par_acc ^ maj;
          if (maj) all_zero <= 1'b0;
          if (bitcnt == nb_l - 4'd1) state <= (par_l == PAR_NONE) ? ST_STOP1 : ST_PARITY;
          else bitcnt <= bitcnt + 4'd1;
        end
        ST_PARITY: if (mid) begin
          perr  <= (maj != par_exp);
          if (maj) all_zero <= 1'b0;
          state <= ST_STOP1;
        end
        ST_STOP1: if (mid) begin
          if (brk_now) begin
            hi_seen <= 1'b0;
            state   <= ST_BRKWAIT;
          end else if (stop2_l) begin
            ferr  <= !maj;
            state <= ST_STOP2;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_STOP2: if (mid) state <= ST_IDLE;
        // Leave only after the line stayed high across a whole tick interval.
        ST_BRKWAIT: begin
          if (!rx_sync) hi_seen <= 1'b0;
          else if (tick) begin
            if (hi_seen) state <= ST_IDLE;
            else hi_seen <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (fin && valid_q && !rx_if.i_ready) ovr_q <= 1'b1;
      else if (i_clr_ovr) ovr_q <= 1'b0;
      if (fin && !(valid_q && !rx_if.i_ready)) begin
        valid_q <= 1'b1;
        data_q  <= shreg;
        perr_q  <= perr && !brk_now;
        ferr_q  <= ferr || !maj;
        brk_q   <= brk_now;
      end else if (valid_q && rx_if.i_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_if.o_data       = data_q;
  assign rx_if.o_valid      = valid_q;
  assign rx_if.o_parity_err = perr_q;
  assign rx_if.o_frame_err  = ferr_q;
  assign rx_if.o_break      = brk_q;
  assign rx_if.dbg_state    = state;
  assign o_overrun          = ovr_q;
  assign o_busy             = (state != ST_IDLE);
endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: directed frames for each called-out case, then random
// frames checked against a frame-level model through an expected queue.
module tb_uart_rx_core;
  import uart_pkg::*;

  localparam int DW  = 9;
  localparam int OVS = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_line;
  logic [15:0] div;
  logic [3:0]  dbits;
  logic [2:0]  par;
  logic        stop2;
  logic        clr_ovr;
  logic        ovr;
  logic        busy;

  uart_rx_core_if #(.DATA_W_MAX(DW)) u_if();

  uart_rx_core #(.DATA_W_MAX(DW), .OVS(OVS), .DIV_W(16)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rx        (rx_line),
    .i_div       (div),
    .i_data_bits (dbits),
    .i_parity    (par),
    .i_stop2     (stop2),
    .rx_if       (u_if),
    .o_overrun   (ovr),
    .i_clr_ovr   (clr_ovr),
    .o_busy      (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- monitor / scoreboard ----------------
  logic [11:0] exp_q[$];
  logic [11:0] got_q[$];
  int          n_valid  = 0;
  int          rise_cyc = 0;
  int          start_cyc = 0;
  logic        valid_d  = 1'b0;
  int          checks = 0;
  int          errors = 0;

  always @(negedge clk) begin
    valid_d <= u_if.o_valid;
    if (u_if.o_valid && !valid_d) begin
      n_valid  <= n_valid + 1;
      rise_cyc <= cyc;
    end
    if (u_if.o_valid && u_if.i_ready)
      got_q.push_back({u_if.o_break, u_if.o_frame_err, u_if.o_parity_err, u_if.o_data});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int clamp_nb(input int raw);
    if (raw < 5) return 5;
    if (raw > DW) return DW;
    return raw;
  endfunction

  function automatic logic [8:0] mask_data(input logic [8:0] val, input int nb);
    logic [8:0] d;
    d = '0;
    for (int i = 0; i < nb; i++) d[i] = val[i];
    return d;
  endfunction

  function automatic bit good_parity(input logic [8:0] val, input int nb, input int pm);
    int ones;
    ones = $countones(mask_data(val, nb));
    case (pm)
      1: return (ones % 2) == 1;
      2: return (ones % 2) == 0;
      3: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Packed result: {break, frame_err, parity_err, data[8:0]}
  function automatic logic [11:0] model(input logic [8:0] val, input int nb, input int pm,
                                        input bit pbit, input bit s1, input bit s2, input bit two);
    logic [8:0] d;
    bit perr, ferr;
    d = mask_data(val, nb);
    if (d == 0 && (pm == 0 || !pbit) && !s1) return {3'b110, 9'h000};
    perr = (pm != 0) && (pbit != good_parity(val, nb, pm));
    ferr = !s1 || (two && !s2);
    return {1'b0, ferr, perr, d};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int bitlen();
    return OVS * ((div == 0) ? 1 : int'(div));
  endfunction

  task automatic send_frame(input logic [8:0] val, input int nb, input int pm,
                            input bit pbit, input bit s1, input bit s2, input bit two);
    bit bq[$];
    int bl;
    bl = bitlen();
    bq.push_back(1'b0);
    for (int i = 0; i < nb; i++) bq.push_back(val[i]);
    if (pm != 0) bq.push_back(pbit);
    bq.push_back(s1);
    if (two) bq.push_back(s2);
    start_cyc = cyc;
    foreach (bq[i]) begin
      rx_line = bq[i];
      step(bl);
    end
    rx_line = 1'b1;
  endtask

  task automatic expect_char(input string tag);
    int n;
    logic [11:0] e;
    n = 0;
    while (got_q.size() == 0 && n < 3000) begin
      step(1);
      n++;
    end
    e = exp_q.pop_front();
    if (got_q.size() == 0) check({tag, "_timeout"}, 32'(got_q.size()), 32'd1);
    else check(tag, {20'h0, got_q.pop_front()}, {20'h0, e});
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int bl, n0, lat, lo, hi, nb, pm, raw;
    bit pb, s1, s2, two;
    logic [8:0] val;

    rst = 1'b1; rx_line = 1'b1; div = 16'd4; dbits = 4'd8; par = 3'd0;
    stop2 = 1'b0; clr_ovr = 1'b0; u_if.i_ready = 1'b1;
    step(5);
    check("rst_valid", u_if.o_valid, 0);
    check("rst_data", u_if.o_data, 0);
    check("rst_flags", {u_if.o_break, u_if.o_frame_err, u_if.o_parity_err, ovr, busy}, 0);
    rst = 1'b0;
    step(5);
    bl = bitlen();

    // 8N1 0xA5 and completion latency
    exp_q.push_back(model(9'h0A5, 8, 0, 0, 1, 1, 0));
    send_frame(9'h0A5, 8, 0, 0, 1, 1, 0);
    lat = rise_cyc - start_cyc;
    lo  = 9 * bl + bl / 2;
    hi  = 9 * bl + (3 * bl) / 4;
    check("a5_latency_window", (lat >= lo && lat <= hi), 1);
    expect_char("a5_8n1");
    step(bl);

    // 7E2: parity forced wrong, then second stop bit low
    dbits = 4'd7; par = 3'd1; stop2 = 1'b1;
    exp_q.push_back(model(9'h035, 7, 1, 1, 1, 1, 1));
    send_frame(9'h035, 7, 1, 1, 1, 1, 1);
    expect_char("7e2_parity");
    step(bl);
    pb = good_parity(9'h035, 7, 1);
    exp_q.push_back(model(9'h035, 7, 1, pb, 1, 0, 1));
    send_frame(9'h035, 7, 1, pb, 1, 0, 1);
    expect_char("7e2_stop2");
    step(bl);

    // Break: 12 low bit times on 8N1
    dbits = 4'd8; par = 3'd0; stop2 = 1'b0;
    n0 = n_valid;
    exp_q.push_back(model(9'h000, 8, 0, 0, 0, 1, 0));
    rx_line = 1'b0;
    step(11 * bl + bl / 2);
    check("brk_busy_low", busy, 1);
    step(bl / 2);
    rx_line = 1'b1;
    check("brk_busy_release", busy, 1);
    step(20);
    check("brk_busy_done", busy, 0);
    check("brk_one_valid", n_valid - n0, 1);
    expect_char("brk_char");
    step(bl);

    // Overrun: second character dropped while first is held
    u_if.i_ready = 1'b0;
    send_frame(9'h011, 8, 0, 0, 1, 1, 0);
    step(bl);
    send_frame(9'h022, 8, 0, 0, 1, 1, 0);
    check("ovr_held_data", u_if.o_data, 9'h011);
    check("ovr_set", {u_if.o_valid, ovr}, 2'b11);
    clr_ovr = 1'b1;
    step(1);
    clr_ovr = 1'b0;
    check("ovr_cleared", ovr, 0);
    exp_q.push_back(model(9'h011, 8, 0, 0, 1, 1, 0));
    u_if.i_ready = 1'b1;
    step(1);
    u_if.i_ready = 1'b0;
    expect_char("ovr_accept_old");
    check("ovr_valid_drop", u_if.o_valid, 0);
    step(bl);

    // Ready pulse in the completion cycle of the second character
    send_frame(9'h011, 8, 0, 0, 1, 1, 0);
    lat = rise_cyc - start_cyc;
    step(bl);
    fork
      send_frame(9'h022, 8, 0, 0, 1, 1, 0);
      begin
        do step(1); while (cyc < start_cyc + lat - 1);
        u_if.i_ready = 1'b1;
        step(1);
        u_if.i_ready = 1'b0;
      end
    join
    exp_q.push_back(model(9'h011, 8, 0, 0, 1, 1, 0));
    expect_char("same_clk_old");
    check("same_clk_new", {u_if.o_valid, ovr, u_if.o_data}, {2'b10, 9'h022});
    exp_q.push_back(model(9'h022, 8, 0, 0, 1, 1, 0));
    u_if.i_ready = 1'b1;
    step(1);
    expect_char("same_clk_accept");
    step(bl);

    // 3-clock glitch is a false start; then 9-bit 0x1FF
    n0 = n_valid;
    rx_line = 1'b0;
    step(3);
    rx_line = 1'b1;
    step(2 * bl);
    check("glitch_no_valid", n_valid - n0, 0);
    check("glitch_idle", busy, 0);
    dbits = 4'd9;
    exp_q.push_back(model(9'h1FF, 9, 0, 0, 1, 1, 0));
    send_frame(9'h1FF, 9, 0, 0, 1, 1, 0);
    expect_char("nine_bit");
    step(bl);

    // Reset during bit 3 of 0x5A, then 0x3C
    dbits = 4'd8;
    n0 = n_valid;
    rx_line = 1'b0; step(bl);
    rx_line = 1'b0; step(bl);
    rx_line = 1'b1; step(bl);
    rx_line = 1'b0; step(bl);
    rx_line = 1'b1; step(bl / 2);
    rst = 1'b1;
    step(4);
    check("mid_rst_outputs", {u_if.o_valid, u_if.o_data, u_if.o_break, u_if.o_frame_err, u_if.o_parity_err, ovr, busy}, 0);
    rst = 1'b0;
    step(2 * bl);
    exp_q.push_back(model(9'h03C, 8, 0, 0, 1, 1, 0));
    send_frame(9'h03C, 8, 0, 0, 1, 1, 0);
    step(bl);
    check("rst_one_char", n_valid - n0, 1);
    expect_char("after_rst_3c");

    // Random frames, configuration varied between frames
    for (int i = 0; i < 24; i++) begin
      div   = 16'($urandom_range(0, 4));
      raw   = $urandom_range(3, 12);
      nb    = clamp_nb(raw);
      pm    = $urandom_range(0, 4);
      two   = 1'($urandom_range(0, 1));
      val   = 9'($urandom_range(0, 511));
      pb    = good_parity(val, nb, pm) ^ ($urandom_range(0, 3) == 0);
      s1    = ($urandom_range(0, 7) != 0);
      s2    = ($urandom_range(0, 7) != 0);
      dbits = 4'(raw);
      par   = 3'(pm);
      stop2 = two;
      exp_q.push_back(model(val, nb, pm, pb, s1, s2, two));
      send_frame(val, nb, pm, pb, s1, s2, two);
      step(bitlen());
      expect_char($sformatf("rand%0d", i));
    end
    check("rand_no_overrun", ovr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
